img_filter_pipe: RTL and testbench

Pipelined, parametrised successor to the display-window filter selector.
- Maps the VGA raster onto a scaled camera window and exports window-local coordinates to external filter engines (mosaic, ASCII, ...).
- Aligns the external filter results with the bypass pixel and adds built-in point filters (grayscale, invert, threshold).
- Switches mode only at frame boundaries, so a frame never shows two filters.
- Sits between the frame-buffer read path and the VGA RGB output.

---
 rtl/img_filter_pkg.sv | 40 ++++
 rtl/img_pix_delay.sv | 43 ++++
 rtl/img_filter_pipe.sv | 167 ++++++++++++++++
 tb/tb_img_filter_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_filter_pkg.sv
// -----------------------------------------------------------------------------
// img_filter_pkg
// Shared types and helpers for the image filter pipeline.
//   filter_mode_e : 3-bit mode code carried with every pixel
//   rgb_t         : pixel record at the default channel width
//   gray_sum      : weighted luma sum r + 2g + b (caller shifts right by 2)
// -----------------------------------------------------------------------------
package img_filter_pkg;

    typedef enum logic [2:0] {
        FM_PASS = 3'd0,
        FM_EXT0 = 3'd1,
        FM_EXT1 = 3'd2,
        FM_EXT2 = 3'd3,
        FM_EXT3 = 3'd4,
        FM_GRAY = 3'd5,
        FM_INV  = 3'd6,
        FM_THR  = 3'd7
    } filter_mode_e;

    localparam int unsigned PIX_CH_W = 4;

    typedef struct packed {
        logic [PIX_CH_W-1:0] r;
        logic [PIX_CH_W-1:0] g;
        logic [PIX_CH_W-1:0] b;
    } rgb_t;

    // Widest channel the helper accepts; the two extra result bits hold the
    // carry of r + 2g + b, so (sum >> 2) truncated to the channel width equals
    // the same sum computed at channel width + 2.
    localparam int unsigned GRAY_IN_W = 16;

    function automatic logic [GRAY_IN_W+1:0] gray_sum(input logic [GRAY_IN_W-1:0] r,
                                                      input logic [GRAY_IN_W-1:0] g,
                                                      input logic [GRAY_IN_W-1:0] b);
        return {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    endfunction

endpackage

// File: rtl/img_pix_delay.sv
// -----------------------------------------------------------------------------
// img_pix_delay
// Generic DEPTH-stage shift register with asynchronous active-low clear.
//   clk   : clock
//   rst_n : asynchronous active-low clear of every stage
//   d_i   : data entering stage 0
//   q_o   : data leaving the last stage (DEPTH cycles after d_i)
// -----------------------------------------------------------------------------
module img_pix_delay #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/img_filter_pipe.sv
// -----------------------------------------------------------------------------
// img_filter_pipe
// Maps the VGA raster onto a scaled camera window, exports window-local
// coordinates to external filter engines, realigns their results with the
// bypass pixel and applies built-in point filters. Mode changes only take
// effect at frame_start; each pixel carries the mode it entered with.
//   clk, reset               : pixel clock, async active-low reset
//   filter_sel, frame_start  : requested mode, frame boundary pulse
//   DE, x_pixel, y_pixel     : raster timing
//   r_in, g_in, b_in         : source pixel
//   local_x, local_y         : window-local coordinates (combinational)
//   filter_en                : DE and inside window (combinational)
//   ext_rgb                  : external results, EXT_LAT cycles after local_*
//   r_out, g_out, b_out      : filtered pixel, EXT_LAT+1 cycles after input
//   de_out                   : DE aligned with r/g/b_out
//   active_sel, sel_pending  : applied mode, request differs from applied
// -----------------------------------------------------------------------------
module img_filter_pipe
    import img_filter_pkg::*;
#(
    parameter int unsigned CH_W        = 4,
    parameter int unsigned IMG_WIDTH   = 160,
    parameter int unsigned IMG_HEIGHT  = 120,
    parameter int unsigned WIN_X0      = 320,
    parameter int unsigned WIN_Y0      = 240,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned NUM_EXT     = 2,
    parameter int unsigned EXT_LAT     = 2,
    parameter int unsigned THRESH      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2:0]                  filter_sel,
    input  logic                        frame_start,
    input  logic                        DE,
    input  logic [9:0]                  x_pixel,
    input  logic [9:0]                  y_pixel,
    input  logic [CH_W-1:0]             r_in,
    input  logic [CH_W-1:0]             g_in,
    input  logic [CH_W-1:0]             b_in,
    output logic [9:0]                  local_x,
    output logic [9:0]                  local_y,
    output logic                        filter_en,
    input  logic [NUM_EXT*3*CH_W-1:0]   ext_rgb,
    output logic [CH_W-1:0]             r_out,
    output logic [CH_W-1:0]             g_out,
    output logic [CH_W-1:0]             b_out,
    output logic                        de_out,
    output logic [2:0]                  active_sel,
    output logic                        sel_pending
);

    localparam int unsigned PIX_W = 3 * CH_W;
    localparam int unsigned TAG_W = PIX_W + 2 + 3;

    // Window bounds in 11 bits so WIN_X0 + scaled width cannot wrap.
    localparam logic [10:0] X_LO = 11'(WIN_X0);
    localparam logic [10:0] X_HI = 11'(WIN_X0 + (IMG_WIDTH << SCALE_SHIFT));
    localparam logic [10:0] Y_LO = 11'(WIN_Y0);
    localparam logic [10:0] Y_HI = 11'(WIN_Y0 + (IMG_HEIGHT << SCALE_SHIFT));

    // ---------------- window test ----------------
    logic [10:0] x_ext, y_ext, dx, dy;
    logic        in_win;

    always_comb begin
        x_ext     = {1'b0, x_pixel};
        y_ext     = {1'b0, y_pixel};
        in_win    = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
        dx        = x_ext - X_LO;
        dy        = y_ext - Y_LO;
        filter_en = DE && in_win;
        local_x   = in_win ? 10'(dx >> SCALE_SHIFT) : '0;
        local_y   = in_win ? 10'(dy >> SCALE_SHIFT) : '0;
    end

    // ---------------- mode latch ----------------
    logic [2:0] active_sel_q, active_sel_d;

    always_comb begin
        active_sel_d = frame_start ? filter_sel : active_sel_q;
        active_sel   = active_sel_q;
        sel_pending  = (filter_sel != active_sel_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_sel_q <= 3'd0;
        end else begin
            active_sel_q <= active_sel_d;
        end
    end

    // ---------------- delay line ----------------
    // The mode tag is the already-latched value, so a pixel entering on the
    // frame_start cycle still belongs to the old frame's mode.
    logic [TAG_W-1:0] dly_in, dly_out;
    logic [PIX_W-1:0] d_pix;
    logic             d_de, d_fen;
    logic [2:0]       d_sel;

    assign dly_in = {r_in, g_in, b_in, DE, filter_en, active_sel_q};

    img_pix_delay #(
        .WIDTH (TAG_W),
        .DEPTH (EXT_LAT)
    ) u_pix_delay (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (dly_in),
        .q_o   (dly_out)
    );

    assign {d_pix, d_de, d_fen, d_sel} = dly_out;

    // ---------------- point ops and mux ----------------
    logic [CH_W-1:0]        d_r, d_g, d_b, gray;
    logic [GRAY_IN_W+1:0]   gsum;
    logic [PIX_W-1:0]       ext_pix, mode_pix;
    logic [PIX_W-1:0]       pix_q, pix_d;
    logic                   de_q, de_d;

    always_comb begin
        d_r  = d_pix[3*CH_W-1 -: CH_W];
        d_g  = d_pix[2*CH_W-1 -: CH_W];
        d_b  = d_pix[CH_W-1:0];
        gsum = gray_sum(GRAY_IN_W'(d_r), GRAY_IN_W'(d_g), GRAY_IN_W'(d_b));
        gray = CH_W'(gsum >> 2);

        // Ext codes beyond NUM_EXT fall through to the bypass pixel.
        ext_pix = d_pix;
        for (int k = 0; k < NUM_EXT; k++) begin
            if (int'(d_sel) == k + 1) begin
                ext_pix = ext_rgb[k*PIX_W +: PIX_W];
            end
        end

        mode_pix = d_pix;
        if (d_fen) begin
            case (filter_mode_e'(d_sel))
                FM_GRAY: mode_pix = {gray, gray, gray};
                FM_INV:  mode_pix = ~d_pix;
                FM_THR:  mode_pix = (32'(gray) >= THRESH) ? '1 : '0;
                default: mode_pix = ext_pix;
            endcase
        end

        pix_d = d_de ? mode_pix : '0;
        de_d  = d_de;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_q <= '0;
            de_q  <= 1'b0;
        end else begin
            pix_q <= pix_d;
            de_q  <= de_d;
        end
    end

    assign r_out  = pix_q[3*CH_W-1 -: CH_W];
    assign g_out  = pix_q[2*CH_W-1 -: CH_W];
    assign b_out  = pix_q[CH_W-1:0];
    assign de_out = de_q;

endmodule

// File: tb/tb_img_filter_pipe.sv
// -----------------------------------------------------------------------------
// tb_img_filter_pipe
// Directed bench for img_filter_pipe at default parameters. Stimulus pushes
// the expected output pixel and its due cycle into a scoreboard; a monitor on
// the falling edge pops and compares whenever de_out is high.
// -----------------------------------------------------------------------------
module tb_img_filter_pipe;

    localparam int CH_W    = 4;
    localparam int NUM_EXT = 2;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic [2:0]                 filter_sel = '0;
    logic                       frame_start = 1'b0;
    logic                       DE = 1'b0;
    logic [9:0]                 x_pixel = '0;
    logic [9:0]                 y_pixel = '0;
    logic [CH_W-1:0]            r_in = '0, g_in = '0, b_in = '0;
    logic [9:0]                 local_x, local_y;
    logic                       filter_en;
    logic [NUM_EXT*3*CH_W-1:0]  ext_rgb = '0;
    logic [CH_W-1:0]            r_out, g_out, b_out;
    logic                       de_out;
    logic [2:0]                 active_sel;
    logic                       sel_pending;

    img_filter_pipe u_dut (
        .clk         (clk),
        .reset       (reset),
        .filter_sel  (filter_sel),
        .frame_start (frame_start),
        .DE          (DE),
        .x_pixel     (x_pixel),
        .y_pixel     (y_pixel),
        .r_in        (r_in),
        .g_in        (g_in),
        .b_in        (b_in),
        .local_x     (local_x),
        .local_y     (local_y),
        .filter_en   (filter_en),
        .ext_rgb     (ext_rgb),
        .r_out       (r_out),
        .g_out       (g_out),
        .b_out       (b_out),
        .de_out      (de_out),
        .active_sel  (active_sel),
        .sel_pending (sel_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        int         due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [23:0] ext_sched [int];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // External filter engine stand-in: replays the value scheduled for this cycle.
    always @(posedge clk) begin
        #1;
        if (ext_sched.exists(cyc)) begin
            ext_rgb = ext_sched[cyc];
            ext_sched.delete(cyc);
        end else begin
            ext_rgb = '0;
        end
    end

    // Monitor: output pixel must arrive exactly on its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (de_out) begin
                if (sb.size() == 0) begin
                    chk("de_out_unexpected", de_out, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_cycle", cyc, mon_e.due);
                    chk("out_r", r_out, mon_e.r);
                    chk("out_g", g_out, mon_e.g);
                    chk("out_b", b_out, mon_e.b);
                end
            end else begin
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    mon_e = sb.pop_front();
                    chk("de_out_missing", de_out, 1);
                end
                chk("blank_rgb", {r_out, g_out, b_out}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        DE = 1'b0;
        tick();
    endtask

    // Drive one DE=1 pixel and record its expected output (latency 3).
    task automatic send(input logic [9:0] x, input logic [9:0] y,
                        input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                        input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb,
                        input logic [23:0] ext);
        DE      = 1'b1;
        x_pixel = x;
        y_pixel = y;
        r_in    = r;
        g_in    = g;
        b_in    = b;
        sb.push_back('{er, eg, eb, cyc + 3});
        if (ext != 0) ext_sched[cyc + 2] = ext;
        #1;
    endtask

    task automatic switch_mode(input logic [2:0] m);
        DE          = 1'b0;
        filter_sel  = m;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("active_sel_after_fs", active_sel, m);
        chk("sel_pending_after_fs", sel_pending, 0);
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        chk("rst_de_out", de_out, 0);
        chk("rst_active_sel", active_sel, 0);
        chk("rst_sel_pending", sel_pending, 0);
        chk("rst_rgb", {r_out, g_out, b_out}, 0);
        tick();

        // Window edges, mode 0 pass-through
        send(10'd319, 10'd240, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 24'h0);
        chk("fen_x319", filter_en, 0);
        chk("lx_x319", local_x, 0);
        chk("ly_x319", local_y, 0);
        tick();
        send(10'd320, 10'd240, 4'd4, 4'd5, 4'd6, 4'd4, 4'd5, 4'd6, 24'h0);
        chk("fen_x320", filter_en, 1);
        chk("lx_x320", local_x, 0);
        chk("ly_y240", local_y, 0);
        tick();
        send(10'd639, 10'd479, 4'd7, 4'd8, 4'd9, 4'd7, 4'd8, 4'd9, 24'h0);
        chk("fen_x639", filter_en, 1);
        chk("lx_x639", local_x, 159);
        chk("ly_y479", local_y, 119);
        tick();
        send(10'd640, 10'd479, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 24'h0);
        chk("fen_x640", filter_en, 0);
        chk("lx_x640", local_x, 0);
        tick();
        send(10'd400, 10'd480, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 24'h0);
        chk("fen_y480", filter_en, 0);
        chk("ly_y480", local_y, 0);
        tick();
        send(10'd323, 10'd245, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 24'h0);
        chk("lx_x323", local_x, 1);
        chk("ly_y245", local_y, 2);
        tick();
        DE = 1'b0; x_pixel = 10'd330; y_pixel = 10'd250;
        #1;
        chk("fen_de0", filter_en, 0);
        tick();

        // Frame-sync latch: request 6 mid-frame, no effect until frame_start
        filter_sel = 3'd6;
        send(10'd320, 10'd240, 4'd3, 4'd0, 4'd15, 4'd3, 4'd0, 4'd15, 24'h0);
        chk("pending_mid_frame", sel_pending, 1);
        chk("active_mid_frame", active_sel, 0);
        tick();
        idle();
        switch_mode(3'd6);
        send(10'd320, 10'd240, 4'd3, 4'd0, 4'd15, 4'd12, 4'd15, 4'd0, 24'h0);
        tick();
        send(10'd100, 10'd100, 4'd3, 4'd0, 4'd15, 4'd3, 4'd0, 4'd15, 24'h0);
        tick();
        idle();

        // External channels and latency
        switch_mode(3'd1);
        repeat (3) idle();
        send(10'd320, 10'd240, 4'd1, 4'd1, 4'd1, 4'hA, 4'h5, 4'hF, 24'h123A5F);
        tick();
        repeat (3) idle();
        switch_mode(3'd2);
        send(10'd320, 10'd240, 4'd1, 4'd1, 4'd1, 4'h3, 4'hC, 4'h7, 24'h3C7456);
        tick();
        switch_mode(3'd3);
        send(10'd320, 10'd240, 4'd6, 4'd7, 4'd8, 4'd6, 4'd7, 4'd8, 24'h789ABC);
        tick();
        idle();

        // Gray and threshold
        switch_mode(3'd5);
        send(10'd320, 10'd240, 4'd4, 4'd8, 4'd12, 4'd8, 4'd8, 4'd8, 24'h0);
        tick();
        send(10'd320, 10'd240, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 24'h0);
        tick();
        send(10'd320, 10'd240, 4'd1, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 24'h0);
        tick();
        switch_mode(3'd7);
        send(10'd320, 10'd240, 4'd4, 4'd8, 4'd12, 4'd15, 4'd15, 4'd15, 24'h0);
        tick();
        send(10'd320, 10'd240, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 24'h0);
        tick();
        send(10'd320, 10'd240, 4'd7, 4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 24'h0);
        tick();
        idle();

        // Mode tag in flight: switch 0 -> 5 with two pixels in the pipe
        switch_mode(3'd0);
        repeat (3) idle();
        send(10'd320, 10'd240, 4'd4, 4'd8, 4'd12, 4'd4, 4'd8, 4'd12, 24'h0);
        tick();
        filter_sel  = 3'd5;
        frame_start = 1'b1;
        send(10'd320, 10'd240, 4'd4, 4'd8, 4'd12, 4'd4, 4'd8, 4'd12, 24'h0);
        tick();
        frame_start = 1'b0;
        chk("active_sel_inflight", active_sel, 5);
        send(10'd320, 10'd240, 4'd4, 4'd8, 4'd12, 4'd8, 4'd8, 4'd8, 24'h0);
        tick();
        repeat (3) idle();

        // Mid-stream reset while in threshold mode
        switch_mode(3'd7);
        send(10'd320, 10'd240, 4'd4, 4'd8, 4'd12, 4'd15, 4'd15, 4'd15, 24'h0);
        tick();
        send(10'd320, 10'd240, 4'd4, 4'd8, 4'd12, 4'd15, 4'd15, 4'd15, 24'h0);
        tick();
        send(10'd320, 10'd240, 4'd4, 4'd8, 4'd12, 4'd15, 4'd15, 4'd15, 24'h0);
        tick();
        send(10'd320, 10'd240, 4'd4, 4'd8, 4'd12, 4'd15, 4'd15, 4'd15, 24'h0);
        reset = 1'b0;
        sb.delete();
        #1;
        chk("midrst_de_out", de_out, 0);
        chk("midrst_rgb", {r_out, g_out, b_out}, 0);
        chk("midrst_active_sel", active_sel, 0);
        tick();
        reset = 1'b1;
        send(10'd320, 10'd240, 4'd4, 4'd8, 4'd12, 4'd4, 4'd8, 4'd12, 24'h0);
        chk("postrst_active_sel", active_sel, 0);
        chk("postrst_pending", sel_pending, 1);
        tick();
        send(10'd320, 10'd240, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 24'h0);
        tick();
        send(10'd320, 10'd240, 4'd9, 4'd1, 4'd5, 4'd9, 4'd1, 4'd5, 24'h0);
        tick();

        repeat (6) idle();
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
